// File: rtl/core_boot_sequencer_pkg.sv
// Shared types for the boot sequencer: network packet, data-memory store port,
// boot FSM states and the parking-packet payload.
package core_boot_sequencer_pkg;

    typedef enum logic [2:0] {
        OpNull  = 3'd0,
        OpInstr = 3'd1,
        OpReg   = 3'd2,
        OpBar   = 3'd3,
        OpPc    = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [4:0]  reserved;
        logic [9:0]  id;
        net_op_e     net_op;
        logic [31:0] net_data;
        logic [9:0]  net_addr;
    } net_packet_s;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] write_data;
        logic        yumi;
    } mem_in_s;

    typedef enum logic [2:0] {
        StIdle,
        StDmem,
        StGap,
        StInstr,
        StReg,
        StBar,
        StPc,
        StRun
    } boot_state_e;

    localparam logic [31:0] kBOOT_PARK_DATA = 32'hFFFF_FFFE;

    // One counter serves every phase, so it is sized for the longest one.
    function automatic int unsigned boot_cnt_width(input int unsigned data_words,
                                                   input int unsigned instr_words,
                                                   input int unsigned reg_words);
        int unsigned longest;
        longest = 2 * data_words;
        if (instr_words > longest) longest = instr_words;
        if (reg_words > longest) longest = reg_words;
        return (longest > 2) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/core_boot_sequencer_if.sv
// Asynchronous-read boot ROM bus: the sequencer drives indices, the ROMs
// return words in the same cycle.
interface core_boot_sequencer_if;
    logic [9:0]  data_rom_addr;
    logic [31:0] data_rom_data;
    logic [9:0]  instr_rom_addr;
    logic [15:0] instr_rom_data;
    logic [5:0]  reg_rom_addr;
    logic [39:0] reg_rom_data;

    modport master (
        output data_rom_addr, instr_rom_addr, reg_rom_addr,
        input  data_rom_data, instr_rom_data, reg_rom_data
    );

    modport slave (
        input  data_rom_addr, instr_rom_addr, reg_rom_addr,
        output data_rom_data, instr_rom_data, reg_rom_data
    );
endinterface

// File: rtl/boot_packet_builder.sv
// Combinational formatter: boot state, phase index and same-cycle ROM data
// to the packet presented to the core.
module boot_packet_builder
    import core_boot_sequencer_pkg::*;
#(
    parameter logic [9:0]  CORE_ID_P  = 10'd1,
    parameter logic [31:0] BAR_MASK_P = 32'h2,
    parameter logic [9:0]  BAR_ADDR_P = 10'd24,
    parameter logic [31:0] START_PC_P = 32'h0
) (
    input  boot_state_e state_i,
    input  logic [9:0]  idx_i,
    input  logic [15:0] instr_data_i,
    input  logic [39:0] reg_data_i,
    output net_packet_s packet_o
);

    logic unused_reg_bits;
    assign unused_reg_bits = ^reg_data_i[39:38];

    always_comb begin
        packet_o = '0;
        unique case (state_i)
            StInstr: begin
                packet_o.id       = CORE_ID_P;
                packet_o.net_op   = OpInstr;
                packet_o.net_data = {16'b0, instr_data_i};
                packet_o.net_addr = idx_i;
            end
            StReg: begin
                packet_o.id       = CORE_ID_P;
                packet_o.net_op   = OpReg;
                packet_o.net_data = reg_data_i[31:0];
                packet_o.net_addr = {4'b0, reg_data_i[37:32]};
            end
            StBar: begin
                packet_o.id       = CORE_ID_P;
                packet_o.net_op   = OpBar;
                packet_o.net_data = BAR_MASK_P;
                packet_o.net_addr = BAR_ADDR_P;
            end
            StPc: begin
                packet_o.id       = CORE_ID_P;
                packet_o.net_op   = OpPc;
                packet_o.net_data = START_PC_P;
            end
            StRun: begin
                packet_o.id       = CORE_ID_P;
                packet_o.net_op   = OpNull;
                packet_o.net_data = kBOOT_PARK_DATA;
                packet_o.net_addr = BAR_ADDR_P;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_boot_sequencer.sv
// Boot engine: fills data memory from the data ROM, streams INSTR/REG packets,
// then BAR and PC, and parks on a NULL packet until reset.
module core_boot_sequencer
    import core_boot_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WORDS_P  = 1024,
    parameter int unsigned INSTR_WORDS_P = 1024,
    parameter int unsigned REG_WORDS_P   = 64,
    parameter logic [9:0]  CORE_ID_P     = 10'd1,
    parameter logic [31:0] BAR_MASK_P    = 32'h2,
    parameter logic [9:0]  BAR_ADDR_P    = 10'd24,
    parameter logic [31:0] START_PC_P    = 32'h0
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          start_i,
    core_boot_sequencer_if.master         rom,
    output logic [$bits(mem_in_s)-1:0]     mem_flat_o,
    output logic [31:0]                   data_mem_addr_o,
    output logic                          select_o,
    output logic [$bits(net_packet_s)-1:0] net_packet_flat_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned CntW = boot_cnt_width(DATA_WORDS_P, INSTR_WORDS_P, REG_WORDS_P);
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t DmemLast  = cnt_t'(2 * DATA_WORDS_P - 1);
    localparam cnt_t InstrLast = cnt_t'(INSTR_WORDS_P - 1);
    localparam cnt_t RegLast   = cnt_t'(REG_WORDS_P - 1);

    boot_state_e state_q;
    cnt_t        cnt_q;
    logic [9:0]  data_idx;
    logic [9:0]  phase_idx;
    mem_in_s     mem_in;
    net_packet_s packet;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (start_i) state_q <= StDmem;
                StDmem: begin
                    if (cnt_q == DmemLast) begin
                        state_q <= StGap;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                StGap: state_q <= StInstr;
                StInstr: begin
                    if (cnt_q == InstrLast) begin
                        state_q <= StReg;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                StReg: begin
                    if (cnt_q == RegLast) begin
                        state_q <= StBar;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                StBar:   state_q <= StPc;
                StPc:    state_q <= StRun;
                StRun:   ;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Each data word is presented for two cycles, so the index is k/2.
    assign data_idx  = 10'(cnt_q >> 1);
    assign phase_idx = 10'(cnt_q);

    always_comb begin
        rom.data_rom_addr  = '0;
        rom.instr_rom_addr = '0;
        rom.reg_rom_addr   = '0;
        mem_in             = '0;
        data_mem_addr_o    = '0;
        unique case (state_q)
            StDmem: begin
                rom.data_rom_addr     = data_idx;
                mem_in.valid          = 1'b1;
                mem_in.yumi           = 1'b1;
                mem_in.wen            = 1'b1;
                mem_in.byte_not_word  = 1'b0;
                mem_in.write_data     = rom.data_rom_data;
                data_mem_addr_o       = {20'b0, data_idx, 2'b00};
            end
            StInstr: rom.instr_rom_addr = phase_idx;
            StReg:   rom.reg_rom_addr   = phase_idx[5:0];
            default: ;
        endcase
    end

    boot_packet_builder #(
        .CORE_ID_P  (CORE_ID_P),
        .BAR_MASK_P (BAR_MASK_P),
        .BAR_ADDR_P (BAR_ADDR_P),
        .START_PC_P (START_PC_P)
    ) u_packet_builder (
        .state_i      (state_q),
        .idx_i        (phase_idx),
        .instr_data_i (rom.instr_rom_data),
        .reg_data_i   (rom.reg_rom_data),
        .packet_o     (packet)
    );

    assign mem_flat_o        = mem_in;
    assign net_packet_flat_o = packet;
    assign select_o          = state_q inside {StInstr, StReg, StBar, StPc, StRun};
    assign busy_o            = (state_q != StIdle) && (state_q != StRun);
    assign done_o            = (state_q == StRun);

endmodule
